// File: rtl/maxpool_pkg.sv
// Shared constants, state encoding and the signed compare helper
// used by the max-pool sequencer and its reduction tree.
package maxpool_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_TAPS = 9;
    localparam logic signed [DATA_W-1:0] PAD_VALUE = 16'sh8000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EMIT,
        DONE
    } state_t;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/max_tree9.sv
// Combinational signed maximum of the nine window taps, arranged as a
// balanced compare tree with the ninth tap joining at the last level.
module max_tree9
    import maxpool_pkg::*;
(
    input  logic [NUM_TAPS-1:0][DATA_W-1:0] taps,
    output logic [DATA_W-1:0]               result
);

    logic signed [DATA_W-1:0] lvl1 [4];
    logic signed [DATA_W-1:0] lvl2 [2];
    logic signed [DATA_W-1:0] lvl3;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lvl1[i] = smax(taps[2*i], taps[2*i+1]);
        end
        lvl2[0] = smax(lvl1[0], lvl1[1]);
        lvl2[1] = smax(lvl1[2], lvl1[3]);
        lvl3    = smax(lvl2[0], lvl2[1]);
        result  = smax(lvl3, taps[NUM_TAPS-1]);
    end

endmodule

// File: rtl/maxpool_seq.sv
// 3x3 max-pool sequencer: walks channels and output positions, fetches the
// nine taps through one RAM read port and streams each window maximum.
module maxpool_seq
    import maxpool_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int CH     = 8,
    parameter int STRIDE = 2,
    parameter int PAD    = 1,
    localparam int OUT_W   = (IMG_W + 2*PAD - 3) / STRIDE + 1,
    localparam int OUT_H   = (IMG_H + 2*PAD - 3) / STRIDE + 1,
    localparam int ADDR_W  = $clog2(CH*IMG_H*IMG_W),
    localparam int OADDR_W = $clog2(CH*OUT_H*OUT_W)
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [OADDR_W-1:0]       out_addr
);

    localparam int CNT_W = 16;
    localparam int K_W   = 4;
    localparam logic [K_W-1:0] LAST_K = K_W'(NUM_TAPS - 1);

    state_t state;

    logic [CNT_W-1:0] ch_cnt, oy_cnt, ox_cnt;
    logic [K_W-1:0]   k_cnt;

    logic [NUM_TAPS-1:0][DATA_W-1:0] taps, taps_next;
    logic [DATA_W-1:0]               tree_max;

    logic           iss_valid, iss_pad, cap_valid, cap_pad;
    logic [K_W-1:0] iss_idx, cap_idx;

    logic last_tap, last_col, last_row, last_ch, last_win, handshake;
    logic [CNT_W-1:0] adv_ch, adv_oy, adv_ox;

    logic             issue;
    logic [CNT_W-1:0] nxt_ch, nxt_oy, nxt_ox;
    logic [K_W-1:0]   nxt_k;
    logic             nxt_pad;
    logic [ADDR_W-1:0] nxt_addr;
    int               ky, kx, row, col;

    assign last_tap  = (k_cnt == LAST_K);
    assign last_col  = (int'(ox_cnt) == OUT_W - 1);
    assign last_row  = (int'(oy_cnt) == OUT_H - 1);
    assign last_ch   = (int'(ch_cnt) == CH - 1);
    assign last_win  = last_col && last_row && last_ch;
    assign handshake = (state == EMIT) && out_valid && out_ready;

    // Raster-order successor of the current window (ox fastest, channel slowest).
    always_comb begin
        adv_ch = ch_cnt;
        adv_oy = oy_cnt;
        adv_ox = ox_cnt + CNT_W'(1);
        if (last_col) begin
            adv_ox = '0;
            adv_oy = oy_cnt + CNT_W'(1);
            if (last_row) begin
                adv_oy = '0;
                adv_ch = ch_cnt + CNT_W'(1);
            end
        end
    end

    // The read strobe is registered, so the tap issued next cycle is chosen one
    // cycle ahead: first tap on start, next tap in FETCH, new window on handshake.
    always_comb begin
        issue  = 1'b0;
        nxt_ch = ch_cnt;
        nxt_oy = oy_cnt;
        nxt_ox = ox_cnt;
        nxt_k  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    issue  = 1'b1;
                    nxt_ch = '0;
                    nxt_oy = '0;
                    nxt_ox = '0;
                end
            end
            FETCH: begin
                if (!last_tap) begin
                    issue = 1'b1;
                    nxt_k = k_cnt + K_W'(1);
                end
            end
            EMIT: begin
                if (handshake && !last_win) begin
                    issue  = 1'b1;
                    nxt_ch = adv_ch;
                    nxt_oy = adv_oy;
                    nxt_ox = adv_ox;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ky       = int'(nxt_k) / 3;
        kx       = int'(nxt_k) % 3;
        row      = int'(nxt_oy) * STRIDE - PAD + ky;
        col      = int'(nxt_ox) * STRIDE - PAD + kx;
        nxt_pad  = (row < 0) || (row >= IMG_H) || (col < 0) || (col >= IMG_W);
        nxt_addr = ADDR_W'(int'(nxt_ch) * (IMG_H*IMG_W) + row * IMG_W + col);
    end

    // Tap capture lands one cycle after the read strobe; padded taps take the
    // most negative value so they can never win the max.
    always_comb begin
        taps_next = taps;
        if (cap_valid) begin
            taps_next[cap_idx] = cap_pad ? PAD_VALUE : rd_data;
        end
    end

    max_tree9 u_tree (
        .taps   (taps_next),
        .result (tree_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ch_cnt    <= '0;
            oy_cnt    <= '0;
            ox_cnt    <= '0;
            k_cnt     <= '0;
            taps      <= '0;
            iss_valid <= 1'b0;
            iss_pad   <= 1'b0;
            iss_idx   <= '0;
            cap_valid <= 1'b0;
            cap_pad   <= 1'b0;
            cap_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            taps      <= taps_next;
            done      <= 1'b0;
            rd_en     <= issue && !nxt_pad;
            iss_valid <= issue;
            iss_idx   <= nxt_k;
            iss_pad   <= nxt_pad;
            cap_valid <= iss_valid;
            cap_idx   <= iss_idx;
            cap_pad   <= iss_pad;
            if (issue) begin
                rd_addr <= nxt_addr;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        ch_cnt <= '0;
                        oy_cnt <= '0;
                        ox_cnt <= '0;
                        k_cnt  <= '0;
                        busy   <= 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    if (last_tap) begin
                        state <= WAIT;
                    end else begin
                        k_cnt <= k_cnt + K_W'(1);
                    end
                end
                WAIT: begin
                    out_valid <= 1'b1;
                    out_data  <= tree_max;
                    out_addr  <= OADDR_W'(int'(ch_cnt) * (OUT_H*OUT_W)
                                          + int'(oy_cnt) * OUT_W + int'(ox_cnt));
                    state     <= EMIT;
                end
                EMIT: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        k_cnt     <= '0;
                        if (last_win) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            ch_cnt <= adv_ch;
                            oy_cnt <= adv_oy;
                            ox_cnt <= adv_ox;
                            state  <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_seq.sv
// Randomised self-checking bench for maxpool_seq on a 4x4x2 map, compared
// against a window-by-window max-pool reference computed from the RAM image.
module tb_maxpool_seq;

    localparam int IMG_W   = 4;
    localparam int IMG_H   = 4;
    localparam int CH      = 2;
    localparam int STRIDE  = 2;
    localparam int PAD     = 1;
    localparam int OUT_W   = (IMG_W + 2*PAD - 3) / STRIDE + 1;
    localparam int OUT_H   = (IMG_H + 2*PAD - 3) / STRIDE + 1;
    localparam int NWIN    = CH * OUT_H * OUT_W;
    localparam int MEM_N   = CH * IMG_H * IMG_W;
    localparam int ADDR_W  = $clog2(MEM_N);
    localparam int OADDR_W = $clog2(NWIN);
    localparam int BUDGET  = 2000;

    logic                clk;
    logic                rst;
    logic                start;
    logic                busy;
    logic                done;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic signed [15:0]  rd_data;
    logic                out_valid;
    logic                out_ready;
    logic signed [15:0]  out_data;
    logic [OADDR_W-1:0]  out_addr;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] mem [MEM_N];
    logic signed [15:0] exp_data [$];
    int                 exp_addr [$];
    int                 exp_rd   [$];

    logic signed [15:0] q_data [$];
    int                 q_addr [$];
    int                 q_rd   [$];
    int                 rd_win     = 0;
    int                 stall_rd   = 0;
    int                 stall_viol = 0;
    int                 done_cnt   = 0;
    logic               prev_stall = 1'b0;
    logic signed [15:0] prev_data  = '0;
    logic [OADDR_W-1:0] prev_addr  = '0;

    maxpool_seq #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .CH     (CH),
        .STRIDE (STRIDE),
        .PAD    (PAD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Feature RAM with one-cycle read latency; junk on the bus when not reading.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= 16'($urandom);
    end

    // Passive monitor: logs handshakes, read counts and backpressure behaviour.
    always @(negedge clk) begin
        if (rst) begin
            rd_win     = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(out_valid === 1'b1 && out_data === prev_data && out_addr === prev_addr))
                stall_viol++;
            if (rd_en === 1'b1) rd_win++;
            if (out_valid === 1'b1 && out_ready === 1'b0 && rd_en === 1'b1) stall_rd++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                q_data.push_back(out_data);
                q_addr.push_back(int'(out_addr));
                q_rd.push_back(rd_win);
                rd_win = 0;
            end
            if (done === 1'b1) done_cnt++;
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_data  = out_data;
            prev_addr  = out_addr;
        end
    end

    // Reference: plain 3x3/stride/pad max over the RAM image, in raster order.
    task automatic build_model();
        exp_data.delete();
        exp_addr.delete();
        exp_rd.delete();
        for (int c = 0; c < CH; c++)
            for (int oy = 0; oy < OUT_H; oy++)
                for (int ox = 0; ox < OUT_W; ox++) begin
                    int best;
                    int nrd;
                    best = -32768;
                    nrd  = 0;
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++) begin
                            int r;
                            int x;
                            int v;
                            r = oy*STRIDE - PAD + ky;
                            x = ox*STRIDE - PAD + kx;
                            if (r >= 0 && r < IMG_H && x >= 0 && x < IMG_W) begin
                                v = int'(mem[c*IMG_H*IMG_W + r*IMG_W + x]);
                                nrd++;
                            end else begin
                                v = -32768;
                            end
                            if (v > best) best = v;
                        end
                    exp_data.push_back(16'(best));
                    exp_addr.push_back(c*OUT_H*OUT_W + oy*OUT_W + ox);
                    exp_rd.push_back(nrd);
                end
    endtask

    task automatic applyStimulus(input bit rand_ready, input bit start_on_done,
                                 output int cycles, output bit timed_out,
                                 output logic busy_at_done);
        int n;
        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < BUDGET) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        timed_out    = (done !== 1'b1);
        busy_at_done = busy;
        cycles       = n + 1;
        if (start_on_done) start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (rd_en !== 1'b0)     begin errors++; $display("[TB] FAIL reset_rd_en got=%b exp=0", rd_en); end
        checks++; if (rd_addr !== '0)     begin errors++; $display("[TB] FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0)    begin errors++; $display("[TB] FAIL reset_out_data got=%0d exp=0", out_data); end
        checks++; if (out_addr !== '0)    begin errors++; $display("[TB] FAIL reset_out_addr got=%0d exp=0", out_addr); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_ramp();
        int base, dbase, cyc;
        bit to;
        logic bd;
        for (int a = 0; a < MEM_N; a++) mem[a] = 16'(a);
        build_model();
        base  = q_data.size();
        dbase = done_cnt;
        applyStimulus(1'b0, 1'b0, cyc, to, bd);
        checks++; if (to) begin errors++; $display("[TB] FAIL ramp_timeout got=%0d exp=0", to); end
        checks++; if (q_data.size() - base != NWIN) begin errors++; $display("[TB] FAIL ramp_count got=%0d exp=%0d", q_data.size() - base, NWIN); end
        for (int i = 0; i < NWIN && base + i < q_data.size(); i++) begin
            checks++; if (q_data[base+i] !== exp_data[i]) begin errors++; $display("[TB] FAIL ramp_data[%0d] got=%0d exp=%0d", i, q_data[base+i], exp_data[i]); end
            checks++; if (q_addr[base+i] != exp_addr[i])  begin errors++; $display("[TB] FAIL ramp_addr[%0d] got=%0d exp=%0d", i, q_addr[base+i], exp_addr[i]); end
            checks++; if (q_rd[base+i] != exp_rd[i])      begin errors++; $display("[TB] FAIL ramp_reads[%0d] got=%0d exp=%0d", i, q_rd[base+i], exp_rd[i]); end
        end
        checks++; if (done_cnt - dbase != 1) begin errors++; $display("[TB] FAIL ramp_done_pulses got=%0d exp=1", done_cnt - dbase); end
        checks++; if (cyc != NWIN*11 + 2)    begin errors++; $display("[TB] FAIL ramp_cycles got=%0d exp=%0d", cyc, NWIN*11 + 2); end
        checks++; if (bd !== 1'b0)           begin errors++; $display("[TB] FAIL ramp_busy_at_done got=%b exp=0", bd); end
    endtask

    task automatic test_all_neg();
        int base, cyc;
        bit to;
        logic bd;
        for (int a = 0; a < MEM_N; a++) mem[a] = -16'sd5;
        build_model();
        base = q_data.size();
        applyStimulus(1'b0, 1'b0, cyc, to, bd);
        checks++; if (q_data.size() - base != NWIN) begin errors++; $display("[TB] FAIL neg_count got=%0d exp=%0d", q_data.size() - base, NWIN); end
        for (int i = 0; i < NWIN && base + i < q_data.size(); i++) begin
            checks++; if (q_data[base+i] !== exp_data[i]) begin errors++; $display("[TB] FAIL neg_data[%0d] got=%0d exp=%0d", i, q_data[base+i], exp_data[i]); end
            checks++; if (q_rd[base+i] != exp_rd[i])      begin errors++; $display("[TB] FAIL neg_reads[%0d] got=%0d exp=%0d", i, q_rd[base+i], exp_rd[i]); end
        end
    endtask

    task automatic test_stall();
        int base, sbase, vbase, cyc;
        bit to;
        logic bd;
        for (int a = 0; a < MEM_N; a++) mem[a] = 16'(a);
        build_model();
        base  = q_data.size();
        sbase = stall_rd;
        vbase = stall_viol;
        fork
            applyStimulus(1'b0, 1'b0, cyc, to, bd);
            begin
                int n;
                n = 0;
                while (q_data.size() - base < 1 && n < BUDGET) begin @(posedge clk); #1; n++; end
                out_ready = 1'b0;
                n = 0;
                while (out_valid !== 1'b1 && n < BUDGET) begin @(posedge clk); #1; n++; end
                for (int s = 0; s < 5; s++) begin
                    checks++; if (out_valid !== 1'b1)       begin errors++; $display("[TB] FAIL stall_valid[%0d] got=%b exp=1", s, out_valid); end
                    checks++; if (out_data !== exp_data[1]) begin errors++; $display("[TB] FAIL stall_data[%0d] got=%0d exp=%0d", s, out_data, exp_data[1]); end
                    checks++; if (int'(out_addr) != exp_addr[1]) begin errors++; $display("[TB] FAIL stall_addr[%0d] got=%0d exp=%0d", s, out_addr, exp_addr[1]); end
                    checks++; if (rd_en !== 1'b0)           begin errors++; $display("[TB] FAIL stall_rd_en[%0d] got=%b exp=0", s, rd_en); end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        checks++; if (to) begin errors++; $display("[TB] FAIL stall_timeout got=%0d exp=0", to); end
        checks++; if (q_data.size() - base != NWIN) begin errors++; $display("[TB] FAIL stall_count got=%0d exp=%0d", q_data.size() - base, NWIN); end
        for (int i = 0; i < NWIN && base + i < q_data.size(); i++) begin
            checks++; if (q_data[base+i] !== exp_data[i]) begin errors++; $display("[TB] FAIL stall_seq[%0d] got=%0d exp=%0d", i, q_data[base+i], exp_data[i]); end
        end
        checks++; if (stall_rd - sbase != 0)   begin errors++; $display("[TB] FAIL stall_reads got=%0d exp=0", stall_rd - sbase); end
        checks++; if (stall_viol - vbase != 0) begin errors++; $display("[TB] FAIL stall_hold got=%0d exp=0", stall_viol - vbase); end
    endtask

    task automatic test_back_to_back();
        int base, dbase, cyc;
        bit to;
        logic bd;
        for (int a = 0; a < MEM_N; a++) mem[a] = 16'(a);
        build_model();
        base  = q_data.size();
        dbase = done_cnt;
        fork
            applyStimulus(1'b0, 1'b1, cyc, to, bd);
            begin
                int n;
                n = 0;
                while (q_data.size() - base < 3 && n < BUDGET) begin @(posedge clk); #1; n++; end
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        checks++; if (q_data.size() - base != NWIN) begin errors++; $display("[TB] FAIL restart_count got=%0d exp=%0d", q_data.size() - base, NWIN); end
        for (int i = 0; i < NWIN && base + i < q_data.size(); i++) begin
            checks++; if (q_data[base+i] !== exp_data[i]) begin errors++; $display("[TB] FAIL restart_data[%0d] got=%0d exp=%0d", i, q_data[base+i], exp_data[i]); end
            checks++; if (q_addr[base+i] != exp_addr[i])  begin errors++; $display("[TB] FAIL restart_addr[%0d] got=%0d exp=%0d", i, q_addr[base+i], exp_addr[i]); end
        end
        checks++; if (cyc != NWIN*11 + 2) begin errors++; $display("[TB] FAIL restart_cycles got=%0d exp=%0d", cyc, NWIN*11 + 2); end
        for (int s = 0; s < 3; s++) begin
            checks++; if (busy !== 1'b0)  begin errors++; $display("[TB] FAIL start_on_done_busy[%0d] got=%b exp=0", s, busy); end
            checks++; if (rd_en !== 1'b0) begin errors++; $display("[TB] FAIL start_on_done_rd_en[%0d] got=%b exp=0", s, rd_en); end
            @(posedge clk); #1;
        end
        checks++; if (done_cnt - dbase != 1) begin errors++; $display("[TB] FAIL restart_done_pulses got=%0d exp=1", done_cnt - dbase); end
    endtask

    task automatic test_random();
        int base, sbase, vbase, cyc;
        bit to;
        logic bd;
        for (int pass = 0; pass < 3; pass++) begin
            for (int a = 0; a < MEM_N; a++) mem[a] = 16'($urandom);
            build_model();
            base  = q_data.size();
            sbase = stall_rd;
            vbase = stall_viol;
            applyStimulus(1'b1, 1'b0, cyc, to, bd);
            checks++; if (to) begin errors++; $display("[TB] FAIL rand_timeout[%0d] got=%0d exp=0", pass, to); end
            checks++; if (q_data.size() - base != NWIN) begin errors++; $display("[TB] FAIL rand_count[%0d] got=%0d exp=%0d", pass, q_data.size() - base, NWIN); end
            for (int i = 0; i < NWIN && base + i < q_data.size(); i++) begin
                checks++; if (q_data[base+i] !== exp_data[i]) begin errors++; $display("[TB] FAIL rand_data[%0d][%0d] got=%0d exp=%0d", pass, i, q_data[base+i], exp_data[i]); end
                checks++; if (q_addr[base+i] != exp_addr[i])  begin errors++; $display("[TB] FAIL rand_addr[%0d][%0d] got=%0d exp=%0d", pass, i, q_addr[base+i], exp_addr[i]); end
            end
            checks++; if (stall_rd - sbase != 0)   begin errors++; $display("[TB] FAIL rand_stall_reads[%0d] got=%0d exp=0", pass, stall_rd - sbase); end
            checks++; if (stall_viol - vbase != 0) begin errors++; $display("[TB] FAIL rand_stall_hold[%0d] got=%0d exp=0", pass, stall_viol - vbase); end
        end
    endtask

    task automatic test_reset_mid();
        int base, n, cyc;
        bit to;
        logic bd;
        for (int a = 0; a < MEM_N; a++) mem[a] = 16'(a);
        build_model();
        base = q_data.size();
        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (q_data.size() - base < OUT_H*OUT_W && n < BUDGET) begin @(posedge clk); #1; n++; end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midpass_busy got=%b exp=1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("[TB] FAIL midrst_done got=%b exp=0", done); end
        checks++; if (rd_en !== 1'b0)     begin errors++; $display("[TB] FAIL midrst_rd_en got=%b exp=0", rd_en); end
        checks++; if (rd_addr !== '0)     begin errors++; $display("[TB] FAIL midrst_rd_addr got=%0d exp=0", rd_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0)    begin errors++; $display("[TB] FAIL midrst_out_data got=%0d exp=0", out_data); end
        checks++; if (out_addr !== '0)    begin errors++; $display("[TB] FAIL midrst_out_addr got=%0d exp=0", out_addr); end
        @(posedge clk); #1;
        rst = 1'b0;
        base = q_data.size();
        applyStimulus(1'b0, 1'b0, cyc, to, bd);
        checks++; if (q_data.size() - base != NWIN) begin errors++; $display("[TB] FAIL rerun_count got=%0d exp=%0d", q_data.size() - base, NWIN); end
        for (int i = 0; i < NWIN && base + i < q_data.size(); i++) begin
            checks++; if (q_data[base+i] !== exp_data[i]) begin errors++; $display("[TB] FAIL rerun_data[%0d] got=%0d exp=%0d", i, q_data[base+i], exp_data[i]); end
            checks++; if (q_rd[base+i] != exp_rd[i])      begin errors++; $display("[TB] FAIL rerun_reads[%0d] got=%0d exp=%0d", i, q_rd[base+i], exp_rd[i]); end
        end
    endtask

    task automatic test_signed();
        int base, cyc;
        bit to;
        logic bd;
        for (int a = 0; a < MEM_N; a++) mem[a] = -16'sd1000;
        mem[0] = 16'sd100;
        mem[1*IMG_W + 1] = -16'sd32768;
        build_model();
        base = q_data.size();
        applyStimulus(1'b0, 1'b0, cyc, to, bd);
        checks++; if (q_data.size() - base != NWIN) begin errors++; $display("[TB] FAIL signed_count got=%0d exp=%0d", q_data.size() - base, NWIN); end
        if (q_data.size() > base) begin
            checks++; if (q_data[base] !== 16'sd100) begin errors++; $display("[TB] FAIL signed_first got=%0d exp=100", q_data[base]); end
        end
        for (int i = 0; i < NWIN && base + i < q_data.size(); i++) begin
            checks++; if (q_data[base+i] !== exp_data[i]) begin errors++; $display("[TB] FAIL signed_data[%0d] got=%0d exp=%0d", i, q_data[base+i], exp_data[i]); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        rd_data   = '0;
        for (int a = 0; a < MEM_N; a++) mem[a] = '0;
        $display("[TB] maxpool_seq bench start");
        test_reset();
        test_ramp();
        test_all_neg();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_signed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
